// File: rtl/partition_sweep_if.sv
// Bus between the partition sweep sequencer and its host/partition pair.
// The slave modport is the sequencer's view; the master modport is the
// view of whatever drives start/abort and returns the partition outputs.
// Optional trace signals exist only when SWEEP_TRACE_EN is defined.
interface partition_sweep_if #(
    parameter int IN_W  = 7,
    parameter int OUT_W = 4
);
    localparam int HD_W = IN_W + $clog2(OUT_W + 1);

    logic             start;
    logic             abort;
    logic [IN_W-1:0]  pi_o;
    logic [OUT_W-1:0] po_ref_i;
    logic [OUT_W-1:0] po_acc_i;
    logic             busy;
    logic             done;
    logic [IN_W:0]    err_cnt;
    logic [HD_W-1:0]  hd_sum;
    logic [OUT_W-1:0] max_err;
`ifdef SWEEP_TRACE_EN
    logic             trace_valid;
    logic [IN_W-1:0]  trace_idx;
    logic [OUT_W-1:0] trace_xor;

    modport master (
        output start, abort, po_ref_i, po_acc_i,
        input  pi_o, busy, done, err_cnt, hd_sum, max_err,
               trace_valid, trace_idx, trace_xor
    );
    modport slave (
        input  start, abort, po_ref_i, po_acc_i,
        output pi_o, busy, done, err_cnt, hd_sum, max_err,
               trace_valid, trace_idx, trace_xor
    );
`else
    modport master (
        output start, abort, po_ref_i, po_acc_i,
        input  pi_o, busy, done, err_cnt, hd_sum, max_err
    );
    modport slave (
        input  start, abort, po_ref_i, po_acc_i,
        output pi_o, busy, done, err_cnt, hd_sum, max_err
    );
`endif
endinterface

// File: rtl/partition_sweep_ctrl.sv
// Exhaustive input sweep sequencer for comparing an exact partition with its
// approximate version. Each vector is held SETTLE_CYC cycles, then both
// outputs are captured for one cycle and folded into mismatch count,
// Hamming-distance sum and maximum absolute error.
// Optional macro SWEEP_TRACE_EN adds per-capture trace outputs.
module partition_sweep_ctrl #(
    parameter int IN_W       = 7,
    parameter int OUT_W      = 4,
    parameter int SETTLE_CYC = 1
) (
    input  logic               clk,
    input  logic               rst,
    partition_sweep_if.slave   bus
);
    localparam int HD_W  = IN_W + $clog2(OUT_W + 1);
    localparam int PW    = $clog2(OUT_W + 1);
    localparam int ERR_W = IN_W + 1;
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, DONE} state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   settle_cnt_reg, settle_cnt_next;
    logic [IN_W-1:0]    pi_reg, pi_next;
    logic               busy_reg, busy_next;
    logic               done_reg, done_next;
    logic [ERR_W-1:0]   err_reg, err_next;
    logic [HD_W-1:0]    hd_reg, hd_next;
    logic [OUT_W-1:0]   max_reg, max_next;

    logic [OUT_W-1:0]   diff_xor;
    logic [OUT_W-1:0]   abs_diff;
    logic [PW-1:0]      diff_pop;

    // Difference between the two partition outputs as seen this cycle
    always_comb begin
        diff_xor = bus.po_acc_i ^ bus.po_ref_i;
        abs_diff = (bus.po_acc_i >= bus.po_ref_i) ? (bus.po_acc_i - bus.po_ref_i)
                                                  : (bus.po_ref_i - bus.po_acc_i);
        diff_pop = '0;
        for (int i = 0; i < OUT_W; i++) begin
            diff_pop = diff_pop + PW'(diff_xor[i]);
        end
    end

    // Next-state and datapath update; abort beats capture accumulation
    always_comb begin
        state_next      = state_reg;
        settle_cnt_next = settle_cnt_reg;
        pi_next         = pi_reg;
        busy_next       = busy_reg;
        done_next       = done_reg;
        err_next        = err_reg;
        hd_next         = hd_reg;
        max_next        = max_reg;
        case (state_reg)
            IDLE, DONE: begin
                if (bus.start) begin
                    err_next        = '0;
                    hd_next         = '0;
                    max_next        = '0;
                    done_next       = 1'b0;
                    busy_next       = 1'b1;
                    pi_next         = '0;
                    settle_cnt_next = '0;
                    state_next      = SETTLE;
                end
            end
            SETTLE: begin
                if (bus.abort) begin
                    state_next      = IDLE;
                    busy_next       = 1'b0;
                    done_next       = 1'b0;
                    pi_next         = '0;
                    settle_cnt_next = '0;
                end else begin
                    settle_cnt_next = settle_cnt_reg + CNT_W'(1);
                    if (settle_cnt_reg == CNT_W'(SETTLE_CYC - 1)) begin
                        state_next = CAPTURE;
                    end
                end
            end
            CAPTURE: begin
                if (bus.abort) begin
                    state_next      = IDLE;
                    busy_next       = 1'b0;
                    done_next       = 1'b0;
                    pi_next         = '0;
                    settle_cnt_next = '0;
                end else begin
                    if (diff_xor != '0) begin
                        err_next = err_reg + ERR_W'(1);
                    end
                    hd_next = hd_reg + HD_W'(diff_pop);
                    if (abs_diff > max_reg) begin
                        max_next = abs_diff;
                    end
                    if (&pi_reg) begin
                        state_next = DONE;
                        busy_next  = 1'b0;
                        done_next  = 1'b1;
                    end else begin
                        pi_next         = pi_reg + IN_W'(1);
                        settle_cnt_next = '0;
                        state_next      = SETTLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and result registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            settle_cnt_reg <= '0;
            pi_reg         <= '0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            err_reg        <= '0;
            hd_reg         <= '0;
            max_reg        <= '0;
        end else begin
            state_reg      <= state_next;
            settle_cnt_reg <= settle_cnt_next;
            pi_reg         <= pi_next;
            busy_reg       <= busy_next;
            done_reg       <= done_next;
            err_reg        <= err_next;
            hd_reg         <= hd_next;
            max_reg        <= max_next;
        end
    end

    assign bus.pi_o    = pi_reg;
    assign bus.busy    = busy_reg;
    assign bus.done    = done_reg;
    assign bus.err_cnt = err_reg;
    assign bus.hd_sum  = hd_reg;
    assign bus.max_err = max_reg;

`ifdef SWEEP_TRACE_EN
    // Trace reports every capture cycle; zero whenever no capture is happening
    assign bus.trace_valid = (state_reg == CAPTURE);
    assign bus.trace_idx   = (state_reg == CAPTURE) ? pi_reg   : '0;
    assign bus.trace_xor   = (state_reg == CAPTURE) ? diff_xor : '0;
`endif

endmodule
